blob_tracker: RTL and testbench

Per-frame colour blob tracker feeding the on-screen initialize/control stage. It compares every camera pixel against the selected `goal_pixel` and accumulates the coordinate sums, pixel count and bounding box of all matching pixels over one frame. At end of frame it divides the sums sequentially to produce the blob centroid (`cur_pos_x`, `cur_pos_y`) and a half-extent radius (`cur_rad`). Those three outputs are what the initialize stage draws as the tracking box and latches as `goal_rad`.

---
 rtl/blob_tracker.sv | 257 +++++++++++++++++++++++++
 tb/tb_blob_tracker.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blob_tracker.sv
// ---------------------------------------------------------------------------
// blob_tracker
//
// Per-frame colour blob tracker. Every camera pixel is compared against
// goal_pixel; matching pixels inside the 320x240 image contribute to
// coordinate sums, a pixel count and a bounding box. At frame close the
// accumulators are snapshotted into shadow registers. Two sequential
// restoring divides then turn the sums into a centroid, and the bounding
// box gives a half-extent radius. Accumulation of the next frame runs
// while the divider works on the snapshot.
//
// Ports
//   clk_65mhz   in   1   pixel clock
//   reset       in   1   synchronous, active-high
//   hcount      in  11   pixel column (cam aligned to it)
//   vcount      in  10   pixel row
//   cam         in  12   camera pixel {r,g,b}
//   sw2         in   1   doubled display: image coords are counts >> 1
//   goal_pixel  in  12   target colour
//   track       in   1   tracking enable
//   cur_pos_x   out  9   centroid x (image coordinates)
//   cur_pos_y   out  9   centroid y
//   cur_rad     out  7   blob half-extent, saturating at 127
//   valid       out  1   one-cycle pulse when the outputs are rewritten
//   lost        out  1   last closed frame had too few matches
//   busy        out  1   snapshot is being processed (not in ACCUM)
// ---------------------------------------------------------------------------
module blob_tracker #(
    parameter int         THRESH      = 2,
    parameter int         MIN_PIXELS  = 16,
    parameter logic [9:0] FRAME_END_V = 10'd770
) (
    input  logic        clk_65mhz,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [11:0] cam,
    input  logic        sw2,
    input  logic [11:0] goal_pixel,
    input  logic        track,
    output logic [8:0]  cur_pos_x,
    output logic [8:0]  cur_pos_y,
    output logic [6:0]  cur_rad,
    output logic        valid,
    output logic        lost,
    output logic        busy
);

    localparam logic [2:0] S_ACCUM  = 3'd0;
    localparam logic [2:0] S_LATCH  = 3'd1;
    localparam logic [2:0] S_DIV_X  = 3'd2;
    localparam logic [2:0] S_DIV_Y  = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;

    localparam logic [3:0]  TH4     = 4'(THRESH);
    localparam logic [16:0] MINP    = 17'(MIN_PIXELS);
    localparam logic [4:0]  LAST_STEP = 5'd24;   // 25 quotient bits

    // ---------------- pixel classification ----------------
    logic [10:0] w_ix;
    logic [9:0]  w_iy;
    logic        w_in_region;
    logic        w_match;
    logic        w_close;

    function automatic logic chan_ok(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] d;
        d = (a >= b) ? (a - b) : (b - a);
        return d <= TH4;
    endfunction

    assign w_ix        = sw2 ? {1'b0, hcount[10:1]} : hcount;
    assign w_iy        = sw2 ? {1'b0, vcount[9:1]}  : vcount;
    assign w_in_region = (w_ix < 11'd320) && (w_iy < 10'd240);
    assign w_match     = w_in_region && track
                      && chan_ok(cam[11:8], goal_pixel[11:8])
                      && chan_ok(cam[7:4],  goal_pixel[7:4])
                      && chan_ok(cam[3:0],  goal_pixel[3:0]);
    assign w_close     = (vcount == FRAME_END_V) && (hcount == 11'd0);

    // ---------------- registers ----------------
    logic [2:0]  r_state;

    logic        r_match;
    logic [8:0]  r_px, r_py;

    logic [24:0] r_sum_x, r_sum_y;
    logic [16:0] r_cnt;
    logic [8:0]  r_xmin, r_xmax, r_ymin, r_ymax;

    logic [24:0] r_sh_sum_x, r_sh_sum_y;
    logic [16:0] r_sh_cnt;
    logic [8:0]  r_sh_xmin, r_sh_xmax, r_sh_ymin, r_sh_ymax;

    logic [24:0] r_dvd;     // dividend shifts out the top, quotient shifts in
    logic [16:0] r_rem;
    logic [4:0]  r_step;
    logic [8:0]  r_qx;

    logic [8:0]  r_pos_x, r_pos_y;
    logic [6:0]  r_rad;
    logic        r_valid, r_lost;

    // ---------------- accumulation ----------------
    // The snapshot is taken only in ACCUM; a close seen while busy is
    // dropped and the live accumulators simply keep running.
    logic w_snap;
    assign w_snap = w_close && (r_state == S_ACCUM);

    always_ff @(posedge clk_65mhz) begin
        if (reset) begin
            r_match    <= 1'b0;
            r_px       <= '0;
            r_py       <= '0;
            r_sum_x    <= '0;
            r_sum_y    <= '0;
            r_cnt      <= '0;
            r_xmin     <= 9'd511;
            r_xmax     <= '0;
            r_ymin     <= 9'd511;
            r_ymax     <= '0;
            r_sh_sum_x <= '0;
            r_sh_sum_y <= '0;
            r_sh_cnt   <= '0;
            r_sh_xmin  <= 9'd511;
            r_sh_xmax  <= '0;
            r_sh_ymin  <= 9'd511;
            r_sh_ymax  <= '0;
        end else begin
            // stage 1: classification registered with its coordinates
            r_match <= w_match;
            r_px    <= w_ix[8:0];
            r_py    <= w_iy[8:0];

            // stage 2: accumulate
            if (w_snap) begin
                r_sh_sum_x <= r_sum_x;
                r_sh_sum_y <= r_sum_y;
                r_sh_cnt   <= r_cnt;
                r_sh_xmin  <= r_xmin;
                r_sh_xmax  <= r_xmax;
                r_sh_ymin  <= r_ymin;
                r_sh_ymax  <= r_ymax;
            end
            if (w_snap || !track) begin
                r_sum_x <= '0;
                r_sum_y <= '0;
                r_cnt   <= '0;
                r_xmin  <= 9'd511;
                r_xmax  <= '0;
                r_ymin  <= 9'd511;
                r_ymax  <= '0;
            end else if (r_match) begin
                r_sum_x <= r_sum_x + {16'd0, r_px};
                r_sum_y <= r_sum_y + {16'd0, r_py};
                r_cnt   <= r_cnt + 17'd1;
                if (r_px < r_xmin) r_xmin <= r_px;
                if (r_px > r_xmax) r_xmax <= r_px;
                if (r_py < r_ymin) r_ymin <= r_py;
                if (r_py > r_ymax) r_ymax <= r_py;
            end
        end
    end

    // ---------------- restoring divider step ----------------
    // Remainder is always below the divisor, so 17 bits hold it; the trial
    // value needs one extra bit for the compare.
    logic [17:0] w_trial;
    logic        w_ge;
    logic [16:0] w_rem_nxt;

    assign w_trial   = {r_rem, r_dvd[24]};
    assign w_ge      = w_trial >= {1'b0, r_sh_cnt};
    assign w_rem_nxt = w_ge ? 17'(w_trial - {1'b0, r_sh_cnt}) : w_trial[16:0];

    // ---------------- radius from bounding box ----------------
    logic [9:0] w_dx, w_dy, w_ext;
    logic [8:0] w_half;
    logic [6:0] w_rad;

    assign w_dx   = {1'b0, r_sh_xmax} - {1'b0, r_sh_xmin};
    assign w_dy   = {1'b0, r_sh_ymax} - {1'b0, r_sh_ymin};
    assign w_ext  = ((w_dx > w_dy) ? w_dx : w_dy) + 10'd1;
    assign w_half = w_ext[9:1];
    assign w_rad  = (w_half > 9'd127) ? 7'd127 : w_half[6:0];

    // ---------------- control FSM ----------------
    always_ff @(posedge clk_65mhz) begin
        if (reset) begin
            r_state <= S_ACCUM;
            r_dvd   <= '0;
            r_rem   <= '0;
            r_step  <= '0;
            r_qx    <= '0;
            r_pos_x <= '0;
            r_pos_y <= '0;
            r_rad   <= '0;
            r_valid <= 1'b0;
            r_lost  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_ACCUM: begin
                    if (w_close) r_state <= S_LATCH;
                end
                S_LATCH: begin
                    if ((r_sh_cnt < MINP) || !track) begin
                        // tracking off leaves the lost flag as it was
                        if (track) r_lost <= 1'b1;
                        r_state <= S_ACCUM;
                    end else begin
                        r_lost  <= 1'b0;
                        r_dvd   <= r_sh_sum_x;
                        r_rem   <= '0;
                        r_step  <= '0;
                        r_state <= S_DIV_X;
                    end
                end
                S_DIV_X: begin
                    r_dvd  <= {r_dvd[23:0], w_ge};
                    r_rem  <= w_rem_nxt;
                    r_step <= r_step + 5'd1;
                    if (r_step == LAST_STEP) begin
                        r_qx    <= {r_dvd[7:0], w_ge};
                        r_dvd   <= r_sh_sum_y;
                        r_rem   <= '0;
                        r_step  <= '0;
                        r_state <= S_DIV_Y;
                    end
                end
                S_DIV_Y: begin
                    r_dvd  <= {r_dvd[23:0], w_ge};
                    r_rem  <= w_rem_nxt;
                    r_step <= r_step + 5'd1;
                    if (r_step == LAST_STEP) r_state <= S_UPDATE;
                end
                S_UPDATE: begin
                    // r_dvd now holds the full y quotient
                    r_pos_x <= r_qx;
                    r_pos_y <= r_dvd[8:0];
                    r_rad   <= w_rad;
                    r_valid <= 1'b1;
                    r_state <= S_ACCUM;
                end
                default: r_state <= S_ACCUM;
            endcase
        end
    end

    assign cur_pos_x = r_pos_x;
    assign cur_pos_y = r_pos_y;
    assign cur_rad   = r_rad;
    assign valid     = r_valid;
    assign lost      = r_lost;
    assign busy      = (r_state != S_ACCUM);

endmodule

// File: tb/tb_blob_tracker.sv
// Randomised + directed bench for blob_tracker. Frames are presented as a
// compressed raster (only interesting pixels, then a close cycle). A model
// accumulates matches per frame with plain integer arithmetic; expected
// updates go into a queue that a negedge monitor pops on every valid pulse.
module tb_blob_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [11:0] cam;
    logic        sw2;
    logic [11:0] goal_pixel;
    logic        track;
    logic [8:0]  cur_pos_x, cur_pos_y;
    logic [6:0]  cur_rad;
    logic        valid, lost, busy;

    always #5 clk = ~clk;

    blob_tracker dut (
        .clk_65mhz (clk),
        .reset     (reset),
        .hcount    (hcount),
        .vcount    (vcount),
        .cam       (cam),
        .sw2       (sw2),
        .goal_pixel(goal_pixel),
        .track     (track),
        .cur_pos_x (cur_pos_x),
        .cur_pos_y (cur_pos_y),
        .cur_rad   (cur_rad),
        .valid     (valid),
        .lost      (lost),
        .busy      (busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { int x; int y; int rad; int due; } exp_t;
    exp_t sb[$];

    // model state
    int m_sx, m_sy, m_cnt, m_xmin, m_xmax, m_ymin, m_ymax;
    int m_x = 0, m_y = 0, m_rad = 0;
    int m_lost = 0;

    task automatic chk(input string nm, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // monitor: every valid pulse must match the oldest expected update
    always @(negedge clk) begin : mon
        exp_t e;
        if (valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got valid=1 expected none (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("pos_x", int'(cur_pos_x), e.x);
                chk("pos_y", int'(cur_pos_y), e.y);
                chk("rad",   int'(cur_rad),   e.rad);
                chk("valid_cycle", cyc, e.due);
                chk("lost_at_valid", int'(lost), 0);
            end
        end
    end

    task automatic model_clear();
        m_sx = 0; m_sy = 0; m_cnt = 0;
        m_xmin = 511; m_xmax = 0; m_ymin = 511; m_ymax = 0;
    endtask

    function automatic bit near(input logic [11:0] c, input logic [11:0] g);
        int d;
        for (int ch = 0; ch < 3; ch++) begin
            d = int'(c[4*ch +: 4]) - int'(g[4*ch +: 4]);
            if (d < 0) d = -d;
            if (d > 2) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive_idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            hcount = 11'd1000; vcount = 10'd600; cam = 12'h000;
        end
    endtask

    task automatic send_pixel(input int h, input int v, input logic [11:0] c);
        int ix, iy;
        @(posedge clk); #1;
        hcount = 11'(h); vcount = 10'(v); cam = c;
        ix = sw2 ? h / 2 : h;
        iy = sw2 ? v / 2 : v;
        if (track && ix < 320 && iy < 240 && near(c, goal_pixel)) begin
            m_sx += ix; m_sy += iy; m_cnt++;
            if (ix < m_xmin) m_xmin = ix;
            if (ix > m_xmax) m_xmax = ix;
            if (iy < m_ymin) m_ymin = iy;
            if (iy > m_ymax) m_ymax = iy;
        end
    endtask

    // ends just after the close edge
    task automatic close_frame();
        int ext;
        exp_t e;
        drive_idle(3);
        @(posedge clk); #1;
        hcount = 11'd0; vcount = 10'd770; cam = 12'h000;
        if (track && m_cnt >= 16) begin
            m_x = m_sx / m_cnt;
            m_y = m_sy / m_cnt;
            ext = ((m_xmax - m_xmin) > (m_ymax - m_ymin) ? (m_xmax - m_xmin) : (m_ymax - m_ymin)) + 1;
            m_rad = (ext / 2 > 127) ? 127 : ext / 2;
            e.x = m_x; e.y = m_y; e.rad = m_rad; e.due = cyc + 53;
            sb.push_back(e);
            m_lost = 0;
        end else if (track) begin
            m_lost = 1;
        end
        model_clear();
        drive_idle(1);
    endtask

    task automatic settle_check(input string tag);
        drive_idle(60);
        chk({tag, "_pending"}, sb.size(), 0);
        sb.delete();
        chk({tag, "_lost"}, int'(lost), m_lost);
        chk({tag, "_x"},    int'(cur_pos_x), m_x);
        chk({tag, "_y"},    int'(cur_pos_y), m_y);
        chk({tag, "_rad"},  int'(cur_rad), m_rad);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic square(input int h0, input int v0, input int w, input int hgt,
                          input logic [11:0] c);
        for (int v = v0; v < v0 + hgt; v++) begin
            send_pixel(h0 - 1, v, 12'h000);
            for (int h = h0; h < h0 + w; h++) send_pixel(h, v, c);
            send_pixel(h0 + w, v, 12'h000);
        end
    endtask

    function automatic logic [11:0] perturb(input logic [11:0] g);
        logic [11:0] c;
        int d;
        for (int ch = 0; ch < 3; ch++) begin
            d = int'(g[4*ch +: 4]) + int'($urandom_range(0, 6)) - 3;
            if (d < 0) d = 0;
            if (d > 15) d = 15;
            c[4*ch +: 4] = 4'(d);
        end
        return c;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; sw2 = 1'b0; track = 1'b0; goal_pixel = 12'hF00;
        hcount = 11'd1000; vcount = 10'd600; cam = 12'h000;
        model_clear();
        drive_idle(4);
        reset = 1'b0;
        drive_idle(2);
        chk("rst_x", int'(cur_pos_x), 0);
        chk("rst_y", int'(cur_pos_y), 0);
        chk("rst_rad", int'(cur_rad), 0);
        chk("rst_lost", int'(lost), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(valid), 0);

        // tracking disabled: matching pixels ignored, nothing changes
        for (int f = 0; f < 3; f++) begin
            square(100, 50, 10, 10, 12'hF00);
            close_frame();
            settle_check("notrack");
        end

        track = 1'b1;
        square(100, 50, 10, 10, 12'hF00);
        close_frame();
        settle_check("sq_exact");
        chk("sq_exact_x_const", int'(cur_pos_x), 104);
        chk("sq_exact_y_const", int'(cur_pos_y), 54);
        chk("sq_exact_rad_const", int'(cur_rad), 5);

        square(100, 50, 10, 10, 12'hE11);
        close_frame();
        settle_check("sq_near");
        chk("sq_near_x_const", int'(cur_pos_x), 104);

        square(100, 50, 10, 10, 12'hC00);
        close_frame();
        settle_check("sq_far");
        chk("sq_far_lost_const", int'(lost), 1);

        sw2 = 1'b1;
        for (int v = 100; v < 120; v++)
            for (int h = 200; h < 220; h++) send_pixel(h, v, 12'hF00);
        close_frame();
        settle_check("sq_dbl");
        chk("sq_dbl_x_const", int'(cur_pos_x), 104);
        chk("sq_dbl_y_const", int'(cur_pos_y), 54);
        chk("sq_dbl_rad_const", int'(cur_rad), 5);
        sw2 = 1'b0;

        // threshold boundary: 15 matches loses, 16 updates
        for (int h = 10; h < 25; h++) send_pixel(h, 30, 12'hF00);
        close_frame();
        settle_check("min15");
        chk("min15_lost_const", int'(lost), 1);
        for (int h = 10; h < 26; h++) send_pixel(h, 30, 12'hF00);
        close_frame();
        settle_check("min16");
        chk("min16_x_const", int'(cur_pos_x), 17);
        chk("min16_rad_const", int'(cur_rad), 8);

        // randomised frames
        for (int f = 0; f < 8; f++) begin
            int bw, bh, x0, y0;
            sw2 = 1'($urandom_range(0, 1));
            goal_pixel = 12'($urandom);
            bw = $urandom_range(1, 14);
            bh = $urandom_range(1, 14);
            x0 = $urandom_range(0, 315);
            y0 = $urandom_range(0, 235);
            for (int k = 0; k < 10; k++)
                send_pixel($urandom_range(0, 1343), $urandom_range(0, 767), 12'($urandom));
            for (int y = y0; y < y0 + bh; y++)
                for (int x = x0; x < x0 + bw; x++)
                    send_pixel(sw2 ? 2 * x + $urandom_range(0, 1) : x,
                               sw2 ? 2 * y + $urandom_range(0, 1) : y,
                               perturb(goal_pixel));
            close_frame();
            settle_check("rand");
        end

        // reset sampled at close edge + 30 (inside the y divide)
        sw2 = 1'b0; goal_pixel = 12'hF00;
        square(100, 50, 10, 10, 12'hF00);
        close_frame();
        drive_idle(29);
        reset = 1'b1;
        drive_idle(1);
        reset = 1'b0;
        sb.delete();
        model_clear();
        m_x = 0; m_y = 0; m_rad = 0; m_lost = 0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_x", int'(cur_pos_x), 0);
        chk("midrst_rad", int'(cur_rad), 0);
        chk("midrst_lost", int'(lost), 0);
        settle_check("midrst_quiet");
        square(60, 20, 6, 4, 12'hF00);
        close_frame();
        settle_check("post_rst");

        chk("final_queue", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
